// File: rtl/prbs16_pkg.sv
// Shared definitions for the PRBS16 (x^16+x^15+x^13+x^4+1) receive checker.
package prbs16_pkg;

  localparam int unsigned PRBS_LEN = 16;
  localparam int unsigned TAP_A    = 4;
  localparam int unsigned TAP_B    = 13;
  localparam int unsigned TAP_C    = 15;
  localparam int unsigned TAP_D    = 16;

  typedef enum logic [1:0] {SEED, HUNT, LOCKED} prbs16_chk_state_t;

  // h[1] is the newest accepted bit, h[16] the oldest.
  function automatic logic prbs16_next(input logic [PRBS_LEN:1] h);
    return h[TAP_A] ^ h[TAP_B] ^ h[TAP_C] ^ h[TAP_D];
  endfunction

endpackage

// File: rtl/prbs16_err_counter.sv
// Saturating error counter; a clear on the same edge as an increment yields 1.
module prbs16_err_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) count_d = '0;
    if (inc && (count_d != '1)) count_d = count_d + CNT_W'(1);
  end

  // rst_n is active-high in this codebase despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/prbs16_checker.sv
// Self-synchronising PRBS16 bit-error checker with lock/loss-of-lock FSM.
// Optional macro PRBS16_CHK_FREERUN_EN: free-run the history from predictions while locked.
module prbs16_checker
  import prbs16_pkg::*;
#(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned LOCK_GOOD = 32,
  parameter int unsigned LOSS_ERRS = 8,
  parameter int unsigned LOSS_WIN  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [7:0]  LOCK_GOOD_C = LOCK_GOOD[7:0];
  localparam logic [10:0] LOSS_ERRS_C = LOSS_ERRS[10:0];
  localparam logic [10:0] LOSS_WIN_C  = LOSS_WIN[10:0];
  localparam logic [4:0]  SEED_LAST   = 5'(PRBS_LEN - 1);

  prbs16_chk_state_t   state_q, state_d;
  logic [PRBS_LEN:1]   h_q, h_d, h_shift;
  logic [4:0]          seed_cnt_q, seed_cnt_d;
  logic [7:0]          good_cnt_q, good_cnt_d;
  logic [10:0]         win_cnt_q, win_cnt_d;
  logic [10:0]         err_win_q, err_win_d, err_win_nx;
  logic                locked_q, locked_d;
  logic                err_pulse_q, err_pulse_d;
  logic                pred, mismatch, shift_bit;

  always_comb begin
    pred      = prbs16_next(h_q);
    mismatch  = in_bit ^ pred;
    shift_bit = in_bit;
`ifdef PRBS16_CHK_FREERUN_EN
    if (state_q == LOCKED) shift_bit = pred;
`endif
    h_shift     = {h_q[PRBS_LEN-1:1], shift_bit};
    err_win_nx  = err_win_q + {10'd0, mismatch};

    state_d     = state_q;
    h_d         = h_q;
    seed_cnt_d  = seed_cnt_q;
    good_cnt_d  = good_cnt_q;
    win_cnt_d   = win_cnt_q;
    err_win_d   = err_win_q;
    err_pulse_d = 1'b0;

    if (in_valid) begin
      h_d = h_shift;
      unique case (state_q)
        SEED: begin
          if (seed_cnt_q == SEED_LAST) begin
            state_d    = HUNT;
            seed_cnt_d = '0;
            good_cnt_d = '0;
          end else begin
            seed_cnt_d = seed_cnt_q + 5'd1;
          end
        end
        HUNT: begin
          if (mismatch) begin
            good_cnt_d = '0;
          end else if (good_cnt_q + 8'd1 == LOCK_GOOD_C) begin
            state_d    = LOCKED;
            good_cnt_d = '0;
            win_cnt_d  = '0;
            err_win_d  = '0;
          end else begin
            good_cnt_d = good_cnt_q + 8'd1;
          end
        end
        LOCKED: begin
          err_pulse_d = mismatch;
          if (win_cnt_q + 11'd1 == LOSS_WIN_C) begin
            win_cnt_d = '0;
            err_win_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 11'd1;
            err_win_d = err_win_nx;
          end
          // Loss is judged on the pre-wrap tally so a window-end error still counts.
          if (err_win_nx == LOSS_ERRS_C) begin
            state_d    = SEED;
            seed_cnt_d = '0;
          end
        end
        default: state_d = SEED;
      endcase
      if ((state_q != SEED) && (h_shift == '0)) begin
        state_d    = SEED;
        seed_cnt_d = '0;
        good_cnt_d = '0;
      end
    end
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= SEED;
      h_q         <= '0;
      seed_cnt_q  <= '0;
      good_cnt_q  <= '0;
      win_cnt_q   <= '0;
      err_win_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      seed_cnt_q  <= seed_cnt_d;
      good_cnt_q  <= good_cnt_d;
      win_cnt_q   <= win_cnt_d;
      err_win_q   <= err_win_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  prbs16_err_counter #(.CNT_W(CNT_W)) u_err_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_pulse_d),
    .clr   (clr_cnt),
    .count (err_count)
  );

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;

endmodule

// File: tb/tb_prbs16_checker.sv
// Directed bench for prbs16_checker; a CNT_W=4 twin shares the stimulus for saturation.
module tb_prbs16_checker;

`ifdef PRBS16_CHK_FREERUN_EN
  localparam int FREERUN = 1;
`else
  localparam int FREERUN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_bit, clr_cnt;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic        locked4, err_pulse4;
  logic [3:0]  err_count4;

  int unsigned pass_cnt = 0;
  int unsigned chk_cnt  = 0;
  int          bitn;
  logic [15:0] gen;
  int          pulse_q[$];
  int          exp_pulses[$];

  always #5 clk = ~clk;

  prbs16_checker #(.CNT_W(16), .LOCK_GOOD(32), .LOSS_ERRS(8), .LOSS_WIN(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
  );

  prbs16_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
    .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic gen_bit();
    logic b;
    b   = gen[3] ^ gen[12] ^ gen[14] ^ gen[15];
    gen = {gen[14:0], b};
    return b;
  endfunction

  task automatic drive(input logic v, input logic b, input logic c);
    in_valid = v;
    in_bit   = b;
    clr_cnt  = c;
    @(posedge clk);
    #1;
    if (v) bitn++;
    if (err_pulse) pulse_q.push_back(bitn);
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  task automatic send_gen(input logic flip);
    drive(1'b1, gen_bit() ^ flip, 1'b0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    clr_cnt  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    bitn  = 0;
    gen   = 16'h0001;
    pulse_q.delete();
  endtask

  initial begin
    int lock_at, loss_n, relock_n, fall_n, lock_cycle;
    int base, cnt_at_loss, nflips;
    logic prev, any_lock;

    // Reset values while reset is held
    rst_n = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked", locked, 0);
    check("rst_pulse", err_pulse, 0);
    check("rst_count", err_count, 0);
    check("rst_count4", err_count4, 0);
    do_reset();

    // Clean stream: lock after bit 48
    lock_at = -1;
    for (int i = 0; i < 60; i++) begin
      send_gen(1'b0);
      if (locked && lock_at < 0) lock_at = bitn;
    end
    check("lock_bit", lock_at, 48);
    while (bitn < 199) send_gen(1'b0);
    check("clean_count", err_count, 0);

    // Single flipped bit at 200
    if (FREERUN != 0) exp_pulses = '{200};
    else              exp_pulses = '{200, 204, 213, 215, 216};
    pulse_q.delete();
    while (bitn < 230) send_gen(bitn == 199);
    check("flip_count", err_count, exp_pulses.size());
    check("flip_npulse", pulse_q.size(), exp_pulses.size());
    for (int i = 0; i < exp_pulses.size(); i++)
      check("flip_pulse_pos", (i < pulse_q.size()) ? pulse_q[i] : -1, exp_pulses[i]);
    check("flip_locked", locked, 1);

    // Long clean run keeps the count
    pulse_q.delete();
    repeat (10000) send_gen(1'b0);
    check("long_count", err_count, exp_pulses.size());
    check("long_pulses", pulse_q.size(), 0);
    check("long_locked", locked, 1);

    // clr_cnt on the same edge as a counted error
    while (bitn < 10299) send_gen(1'b0);
    drive(1'b1, gen_bit() ^ 1'b1, 1'b1);
    check("clr_pulse", err_pulse, 1);
    check("clr_count", err_count, 1);
    check("clr_count4", err_count4, 1);
    while (bitn < 10330) send_gen(1'b0);
    base = (FREERUN != 0) ? 1 : 5;
    check("clr_after", err_count, base);

    // 8 inverted bits inside one window: loss then relock 48 bits later
    while (bitn < 10929) send_gen(1'b0);
    loss_n = -1; relock_n = -1; cnt_at_loss = -1;
    prev = locked;
    for (int n = 0; n < 100; n++) begin
      send_gen(n < 8);
      if (prev && !locked && loss_n < 0) begin
        loss_n      = n;
        cnt_at_loss = err_count;
      end
      if (!prev && locked && loss_n >= 0 && relock_n < 0) relock_n = n;
      prev = locked;
    end
    check("loss_bit", loss_n, (FREERUN != 0) ? 7 : 11);
    check("loss_errs", cnt_at_loss - base, 8);
    check("relock_gap", relock_n - loss_n, 48);
    check("loss_count4", err_count4, base + 8);
    check("relock_locked", locked, 1);

    // Line stuck at 0 while locked
    fall_n = -1;
    for (int n = 0; n < 64; n++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (!locked && fall_n < 0) fall_n = n;
    end
    check("stuck_locked_fall", fall_n >= 0, 1);
    any_lock = 1'b0;
    repeat (100) begin
      drive(1'b1, 1'b0, 1'b0);
      any_lock |= locked;
    end
    check("stuck_stays_unlocked", any_lock, 0);

    // in_valid toggling: 48 valid bits take 96 cycles
    do_reset();
    lock_cycle = -1;
    for (int c = 1; c <= 200; c++) begin
      if (c % 2 == 0) drive(1'b1, gen_bit(), 1'b0);
      else            drive(1'b0, 1'b0, 1'b0);
      if (locked && lock_cycle < 0) lock_cycle = c;
    end
    check("toggle_lock_cycle", lock_cycle, 96);

    // Asynchronous reset while locked with a fresh error pending on outputs
    send_gen(1'b1);
    check("pre_rst_pulse", err_pulse, 1);
    check("pre_rst_count", err_count, 1);
    #1 rst_n = 1'b1;
    #1;
    check("async_locked", locked, 0);
    check("async_pulse", err_pulse, 0);
    check("async_count", err_count, 0);

    // Stuck at 0 from reset never locks
    do_reset();
    any_lock = 1'b0;
    repeat (300) begin
      drive(1'b1, 1'b0, 1'b0);
      any_lock |= locked;
    end
    check("stuck0_never_lock", any_lock, 0);
    check("stuck0_count", err_count, 0);

    // 20 counted errors: wide counter reads 20, 4-bit twin saturates
    do_reset();
    repeat (60) send_gen(1'b0);
    check("sat_pre_locked", locked, 1);
    nflips = (FREERUN != 0) ? 20 : 4;
    for (int k = 0; k < nflips; k++) begin
      send_gen(1'b1);
      repeat (99) send_gen(1'b0);
    end
    check("sat_count16", err_count, 20);
    check("sat_count4", err_count4, 15);
    check("sat_locked4", locked4, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
